mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the five-stage pipelined RV32I core, between the execute stage and the writeback stage. It holds the execute-to-memory pipeline register, runs the load/store handshake with data memory, and formats load data. It presents the signals the writeback stage registers each cycle. A small FSM stalls the upstream pipeline while a data-memory transaction is outstanding, and times out hung transactions.

## Interface
- WIDTH, 32, datapath width
- DMEM_TIMEOUT, 64, max wait cycles for dmem_ready before bus error (≥2)

- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- RegWriteE, ResultSrcE[1:0], MemWriteE, Funct3E[2:0]  in  1/2/1/3  execute-stage controls; ResultSrcE=01 means load
- ALUResultE, WriteDataE, PCPlus4E  in  WIDTH each  execute-stage data
- RdE  in  5  destination register
- FlushM  in  1  insert bubble into M register
- StallM  out  1  hold execute and earlier stages
- RegWriteM, ResultSrcM[1:0], ALUResultM, ReadDataM, RdM, PCPlus4M  out  to writeback stage
- BusErrM  out  1  one-cycle pulse on data-memory timeout
- MisalignM  out  1  one-cycle pulse on misaligned access; only with the macro below
- dmem_req, dmem_we  out  1  request, write enable
- dmem_addr, dmem_wdata  out  WIDTH  word-aligned address ({ALUResultM[31:2],2'b00}), write data
- dmem_be  out  4  byte enables
- dmem_rdata  in  WIDTH  read data, valid when dmem_ready=1
- dmem_ready  in  1  transfer completes on the cycle req&ready are both 1

## Operation
- M register loads all E inputs on clk when StallM=0; if FlushM=1 at that edge it loads a bubble: all controls 0, data 0. FlushM is ignored while StallM=1.
- Memory op means the M register holds a load (ResultSrc=01) or a store (MemWrite=1). All other instructions pass through in 1 cycle.
- FSM states are IDLE, BUSY and DONE.
  - IDLE with a memory op: dmem_req=1 and StallM=1. If dmem_ready, go to DONE; otherwise go to BUSY.
  - BUSY: dmem_req=1 and StallM=1. Wait counter increments. dmem_ready takes the FSM to DONE.
  - BUSY timeout: when the counter reaches DMEM_TIMEOUT-1 without ready, go to DONE with error. BusErrM pulses, ReadDataM=0 and RegWriteM is suppressed.
  - DONE: StallM=0 and dmem_req=0. The next instruction loads and the FSM returns to IDLE.
- Load data is captured into a ReadDataM register on the handshake cycle, using byte lane ALUResultM[1:0]:
  - LB/LBU (000/100): selected byte, sign- or zero-extended.
  - LH/LHU (001/101): half selected by addr[1], sign- or zero-extended.
  - LW (010): full word.
- Stores:
  - SB: dmem_be=0001<<addr[1:0], wdata = byte replicated ×4.
  - SH: dmem_be=0011<<{addr[1],0}, wdata = half replicated ×2.
  - SW: dmem_be=1111.
  - Loads drive dmem_be=1111 and dmem_we=0.
- RegWriteM output = registered RegWrite AND NOT StallM, so the writeback register sees a bubble on every stalled cycle. MemWrite never reaches writeback.

## Timing
- Reset: all M-register fields 0, FSM in IDLE, counter 0, ReadDataM 0. Outputs all 0: dmem_req, StallM, BusErrM, MisalignM. An in-flight request is dropped on the cycle after rst.
- Non-memory instruction occupies M for 1 cycle.
- Memory op with zero-wait memory (ready tied 1) occupies M for 2 cycles; each wait cycle adds 1.
- Timeout path occupies M for DMEM_TIMEOUT+1 cycles.
- dmem_addr, wdata, be and we are stable from the first req cycle until the handshake.
- Back-to-back memory ops each take the full sequence; there is no overlap.

## Configuration
- MEM_MISALIGN_CHECK_EN defined:
  - LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0, issues no request.
  - The instruction completes in 1 cycle with a MisalignM pulse and RegWriteM suppressed.
- Not defined:
  - Half accesses ignore addr[0]; word accesses ignore addr[1:0].
  - MisalignM tied 0.

## Test plan
- rst held 3 cycles mid-BUSY → next cycle dmem_req=0, StallM=0, all outputs 0, FSM IDLE.
- SW 0xDEADBEEF to 0x100, ready tied 1 → one req cycle with we=1, be=1111, addr=0x100; StallM high 1 cycle; RegWriteM=0.
- LB from 0x103, rdata=0x80FF_0000, ready after 3 waits → ReadDataM=0xFFFFFF80; StallM high 4 cycles; RegWriteM=1 only on the DONE cycle. LBU on the same access gives 0x00000080.
- SH 0x1234 to 0x102 → be=1100, wdata=0x12341234.
- Ready never asserted, DMEM_TIMEOUT=64 → BusErrM single pulse, ReadDataM=0, RegWriteM=0; the pipeline resumes.
- With MEM_MISALIGN_CHECK_EN, LW at 0x101 → no dmem_req, MisalignM pulse, StallM stays 0.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: RV32I memory-access stage with execute-to-memory register, dmem handshake FSM and load/store formatting.
// Define MEM_MISALIGN_CHECK_EN to trap misaligned half/word accesses instead of issuing them.
module mem_stage #(
   parameter int WIDTH        = 32,
   parameter int DMEM_TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             RegWriteE,
   input  logic [1:0]       ResultSrcE,
   input  logic             MemWriteE,
   input  logic [2:0]       Funct3E,
   input  logic [WIDTH-1:0] ALUResultE,
   input  logic [WIDTH-1:0] WriteDataE,
   input  logic [WIDTH-1:0] PCPlus4E,
   input  logic [4:0]       RdE,
   input  logic             FlushM,
   output logic             StallM,
   output logic             RegWriteM,
   output logic [1:0]       ResultSrcM,
   output logic [WIDTH-1:0] ALUResultM,
   output logic [WIDTH-1:0] ReadDataM,
   output logic [4:0]       RdM,
   output logic [WIDTH-1:0] PCPlus4M,
   output logic             BusErrM,
   output logic             MisalignM,
   output logic             dmem_req,
   output logic             dmem_we,
   output logic [WIDTH-1:0] dmem_addr,
   output logic [WIDTH-1:0] dmem_wdata,
   output logic [3:0]       dmem_be,
   input  logic [WIDTH-1:0] dmem_rdata,
   input  logic             dmem_ready
);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   localparam int CW = $clog2(DMEM_TIMEOUT) + 1;
   state_t state, state_n;
   logic [CW-1:0] cnt;
   logic reg_write, mem_write, err, mem_op, misalign, timeout, hs;
   logic [2:0] funct3;
   logic [WIDTH-1:0] write_data, load_data;
   logic [7:0] lb;
   logic [15:0] lh;

   always_ff @(posedge clk) begin
      if (rst || (!StallM && FlushM)) begin
         reg_write  <= 1'b0;
         ResultSrcM <= '0;
         mem_write  <= 1'b0;
         funct3     <= '0;
         ALUResultM <= '0;
         write_data <= '0;
         PCPlus4M   <= '0;
         RdM        <= '0;
      end else if (!StallM) begin
         reg_write  <= RegWriteE;
         ResultSrcM <= ResultSrcE;
         mem_write  <= MemWriteE;
         funct3     <= Funct3E;
         ALUResultM <= ALUResultE;
         write_data <= WriteDataE;
         PCPlus4M   <= PCPlus4E;
         RdM        <= RdE;
      end
   end

   assign mem_op = (ResultSrcM == 2'b01) || mem_write;

`ifdef MEM_MISALIGN_CHECK_EN
   assign misalign  = mem_op && (funct3[1:0] == 2'b01 ? ALUResultM[0] :
                                 funct3[1:0] == 2'b10 ? |ALUResultM[1:0] : 1'b0);
   assign MisalignM = misalign;
`else
   assign misalign  = 1'b0;
   assign MisalignM = 1'b0;
`endif

   always_comb begin
      state_n  = IDLE;
      dmem_req = (state == IDLE && mem_op && !misalign) || state == BUSY;
      StallM   = dmem_req;
      timeout  = state == BUSY && !dmem_ready && cnt == CW'(DMEM_TIMEOUT - 1);
      hs       = dmem_req && dmem_ready;
      if (dmem_req) state_n = (dmem_ready || timeout) ? DONE : BUSY;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         err       <= 1'b0;
         ReadDataM <= '0;
      end else begin
         state     <= state_n;
         cnt       <= (state_n == BUSY) ? cnt + CW'(1) : '0;
         err       <= timeout;
         ReadDataM <= timeout ? '0 : (hs && ResultSrcM == 2'b01) ? load_data : ReadDataM;
      end
   end

   // Byte/half lanes picked from the word-aligned read data by the low address bits.
   assign lb = dmem_rdata[{ALUResultM[1:0], 3'b000} +: 8];
   assign lh = dmem_rdata[{ALUResultM[1], 4'b0000} +: 16];
   assign load_data = funct3[1:0] == 2'b00 ? {{(WIDTH-8){~funct3[2] & lb[7]}}, lb} :
                      funct3[1:0] == 2'b01 ? {{(WIDTH-16){~funct3[2] & lh[15]}}, lh} : dmem_rdata;

   assign dmem_we    = mem_write;
   assign dmem_addr  = {ALUResultM[WIDTH-1:2], 2'b00};
   assign dmem_wdata = funct3[1:0] == 2'b00 ? {(WIDTH/8){write_data[7:0]}} :
                       funct3[1:0] == 2'b01 ? {(WIDTH/16){write_data[15:0]}} : write_data;
   assign dmem_be    = !mem_write ? 4'b1111 :
                       funct3[1:0] == 2'b00 ? 4'b0001 << ALUResultM[1:0] :
                       funct3[1:0] == 2'b01 ? 4'b0011 << {ALUResultM[1], 1'b0} : 4'b1111;

   assign RegWriteM = reg_write && !StallM && !err && !misalign;
   assign BusErrM   = err;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: scoreboard bench for mem_stage; a responder models dmem latency, a monitor checks handshakes, writebacks, stalls and errors.
module tb_mem_stage;
   localparam int W  = 32;
   localparam int TO = 64;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic RegWriteE = 0, MemWriteE = 0, FlushM = 0;
   logic [1:0] ResultSrcE = 0;
   logic [2:0] Funct3E = 0;
   logic [W-1:0] ALUResultE = 0, WriteDataE = 0, PCPlus4E = 0;
   logic [4:0] RdE = 0;
   logic StallM, RegWriteM, BusErrM, MisalignM, dmem_req, dmem_we;
   logic [1:0] ResultSrcM;
   logic [W-1:0] ALUResultM, ReadDataM, PCPlus4M, dmem_addr, dmem_wdata;
   logic [4:0] RdM;
   logic [3:0] dmem_be;
   logic [W-1:0] dmem_rdata = 0;
   logic dmem_ready = 0;

   always #5 clk = ~clk;

   mem_stage #(.WIDTH(W), .DMEM_TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE), .Funct3E(Funct3E),
      .ALUResultE(ALUResultE), .WriteDataE(WriteDataE), .PCPlus4E(PCPlus4E), .RdE(RdE),
      .FlushM(FlushM), .StallM(StallM), .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM),
      .ALUResultM(ALUResultM), .ReadDataM(ReadDataM), .RdM(RdM), .PCPlus4M(PCPlus4M),
      .BusErrM(BusErrM), .MisalignM(MisalignM), .dmem_req(dmem_req), .dmem_we(dmem_we),
      .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
      .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready)
   );

   typedef struct { logic [31:0] addr; logic we; logic [3:0] be; logic [31:0] wdata; } hs_t;
   typedef struct { logic [4:0] rd; logic [1:0] rs; logic [31:0] val; } wb_t;
   typedef struct { int wt; logic [31:0] rdata; } mem_t;

   hs_t hs_q[$];
   wb_t wb_q[$];
   int stall_q[$];
   mem_t mem_q[$];
   int err_n = 0, mis_n = 0;
   int tests = 0, fails = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic unexpected(input string name);
      tests++;
      fails++;
      $display("FAIL %s: unexpected event at %0t", name, $time);
   endtask

   // dmem responder: each transaction takes its latency/data from mem_q; wt<0 never answers.
   mem_t cur;
   int rc = 0;
   bit active = 0;
   always @(negedge clk) begin
      if (rst || !dmem_req) begin
         active = 0;
         rc = 0;
         dmem_ready = 0;
      end else begin
         if (!active) begin
            if (mem_q.size() == 0) begin
               unexpected("dmem_req");
               cur = '{-1, 32'h0};
            end else cur = mem_q.pop_front();
            dmem_rdata = cur.rdata;
            active = 1;
            rc = 0;
         end
         dmem_ready = cur.wt >= 0 && rc == cur.wt;
         if (dmem_ready) active = 0;
         else rc++;
      end
   end

   // monitor
   hs_t eh;
   wb_t ew;
   int run = 0;
   int sexp;
   always @(negedge clk) begin
      #1;
      if (rst) run = 0;
      else begin
         if (dmem_req && dmem_ready) begin
            if (hs_q.size() == 0) unexpected("handshake");
            else begin
               eh = hs_q.pop_front();
               chk("hs_addr", dmem_addr, eh.addr);
               chk("hs_we", {31'b0, dmem_we}, {31'b0, eh.we});
               chk("hs_be", {28'b0, dmem_be}, {28'b0, eh.be});
               if (eh.we) chk("hs_wdata", dmem_wdata, eh.wdata);
            end
         end
         if (RegWriteM) begin
            if (wb_q.size() == 0) unexpected("writeback");
            else begin
               ew = wb_q.pop_front();
               chk("wb_rd", {27'b0, RdM}, {27'b0, ew.rd});
               chk("wb_src", {30'b0, ResultSrcM}, {30'b0, ew.rs});
               chk("wb_val", ew.rs == 2'b00 ? ALUResultM : ew.rs == 2'b01 ? ReadDataM : PCPlus4M, ew.val);
            end
         end
         if (BusErrM) begin
            if (err_n == 0) unexpected("buserr");
            else begin
               err_n--;
               chk("buserr_rdata", ReadDataM, 32'h0);
               chk("buserr_regwrite", {31'b0, RegWriteM}, 32'h0);
            end
         end
         if (MisalignM) begin
            if (mis_n == 0) unexpected("misalign");
            else begin
               mis_n--;
               chk("mis_req", {31'b0, dmem_req}, 32'h0);
               chk("mis_stall", {31'b0, StallM}, 32'h0);
               chk("mis_regwrite", {31'b0, RegWriteM}, 32'h0);
            end
         end
         if (StallM) run++;
         else if (run > 0) begin
            if (stall_q.size() == 0) unexpected("stall");
            else begin
               sexp = stall_q.pop_front();
               chk("stall_len", run, sexp);
            end
            run = 0;
         end
      end
   end

   task automatic exp_hs(input logic [31:0] a, input logic we, input logic [3:0] be, input logic [31:0] wd);
      hs_q.push_back('{a, we, be, wd});
   endtask
   task automatic exp_wb(input logic [4:0] rd, input logic [1:0] rs, input logic [31:0] v);
      wb_q.push_back('{rd, rs, v});
   endtask
   task automatic mem(input int wt, input logic [31:0] d);
      mem_q.push_back('{wt, d});
   endtask

   // Called at a negedge; returns at the negedge after the M register accepts the instruction.
   task automatic issue(input logic rw, input logic [1:0] rs, input logic mw, input logic [2:0] f3,
                        input logic [31:0] alu, input logic [31:0] wd, input logic [31:0] pc,
                        input logic [4:0] rd, input logic fl);
      int n = 0;
      RegWriteE = rw; ResultSrcE = rs; MemWriteE = mw; Funct3E = f3;
      ALUResultE = alu; WriteDataE = wd; PCPlus4E = pc; RdE = rd; FlushM = fl;
      while (StallM && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) unexpected("issue_timeout");
      @(posedge clk);
      @(negedge clk);
      RegWriteE = 0; ResultSrcE = 0; MemWriteE = 0; Funct3E = 0;
      ALUResultE = 0; WriteDataE = 0; PCPlus4E = 0; RdE = 0; FlushM = 0;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_req"}, {31'b0, dmem_req}, 32'h0);
      chk({tag, "_stall"}, {31'b0, StallM}, 32'h0);
      chk({tag, "_regwrite"}, {31'b0, RegWriteM}, 32'h0);
      chk({tag, "_buserr"}, {31'b0, BusErrM}, 32'h0);
      chk({tag, "_misalign"}, {31'b0, MisalignM}, 32'h0);
      chk({tag, "_rdata"}, ReadDataM, 32'h0);
      chk({tag, "_rd"}, {27'b0, RdM}, 32'h0);
      chk({tag, "_alu"}, ALUResultM, 32'h0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      #2 chk_idle("reset");
      rst = 0;
      // ALU op passes straight through
      exp_wb(5, 2'b00, 32'h12345678);
      issue(1, 2'b00, 0, 3'b000, 32'h12345678, 0, 32'h104, 5, 0);
      // SW zero-wait
      mem(0, 0); exp_hs(32'h100, 1, 4'b1111, 32'hDEADBEEF); stall_q.push_back(1);
      issue(0, 2'b00, 1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h108, 0, 0);
      // LB / LBU lane 3 with 3 waits
      mem(3, 32'h80FF0000); exp_hs(32'h100, 0, 4'b1111, 0); stall_q.push_back(4); exp_wb(7, 2'b01, 32'hFFFFFF80);
      issue(1, 2'b01, 0, 3'b000, 32'h103, 0, 0, 7, 0);
      mem(3, 32'h80FF0000); exp_hs(32'h100, 0, 4'b1111, 0); stall_q.push_back(4); exp_wb(8, 2'b01, 32'h00000080);
      issue(1, 2'b01, 0, 3'b100, 32'h103, 0, 0, 8, 0);
      // SH to upper half, SB to lane 1
      mem(1, 0); exp_hs(32'h100, 1, 4'b1100, 32'h12341234); stall_q.push_back(2);
      issue(0, 2'b00, 1, 3'b001, 32'h102, 32'hABCD1234, 0, 0, 0);
      mem(0, 0); exp_hs(32'h100, 1, 4'b0010, 32'h5A5A5A5A); stall_q.push_back(1);
      issue(0, 2'b00, 1, 3'b000, 32'h101, 32'h0000005A, 0, 0, 0);
      // LH upper half signed, LHU lower half
      mem(0, 32'h80FF0000); exp_hs(32'h100, 0, 4'b1111, 0); stall_q.push_back(1); exp_wb(9, 2'b01, 32'hFFFF80FF);
      issue(1, 2'b01, 0, 3'b001, 32'h102, 0, 0, 9, 0);
      mem(0, 32'h80FF8001); exp_hs(32'h100, 0, 4'b1111, 0); stall_q.push_back(1); exp_wb(10, 2'b01, 32'h00008001);
      issue(1, 2'b01, 0, 3'b101, 32'h100, 0, 0, 10, 0);
      // LW with 2 waits
      mem(2, 32'hCAFEF00D); exp_hs(32'h200, 0, 4'b1111, 0); stall_q.push_back(3); exp_wb(11, 2'b01, 32'hCAFEF00D);
      issue(1, 2'b01, 0, 3'b010, 32'h200, 0, 0, 11, 0);
      // JAL-style PC+4 writeback
      exp_wb(1, 2'b10, 32'h208);
      issue(1, 2'b10, 0, 3'b000, 32'h999, 0, 32'h208, 1, 0);
      // Timeout: stalls TO cycles, bus error, no writeback, then resumes
      mem(-1, 0); stall_q.push_back(TO); err_n++;
      issue(1, 2'b01, 0, 3'b010, 32'h300, 0, 0, 12, 0);
      exp_wb(13, 2'b00, 32'h55);
      issue(1, 2'b00, 0, 3'b000, 32'h55, 0, 0, 13, 0);
      // Flushed instruction never reaches writeback
      issue(1, 2'b00, 0, 3'b000, 32'h77, 0, 0, 20, 1);
      exp_wb(21, 2'b00, 32'h66);
      issue(1, 2'b00, 0, 3'b000, 32'h66, 0, 0, 21, 0);
      // Back-to-back SW then LW
      mem(0, 0); exp_hs(32'h104, 1, 4'b1111, 32'h11223344); stall_q.push_back(1);
      issue(0, 2'b00, 1, 3'b010, 32'h104, 32'h11223344, 0, 0, 0);
      mem(0, 32'h11223344); exp_hs(32'h104, 0, 4'b1111, 0); stall_q.push_back(1); exp_wb(22, 2'b01, 32'h11223344);
      issue(1, 2'b01, 0, 3'b010, 32'h104, 0, 0, 22, 0);
`ifdef MEM_MISALIGN_CHECK_EN
      mis_n++;
      issue(1, 2'b01, 0, 3'b010, 32'h101, 0, 0, 14, 0);
      exp_wb(23, 2'b00, 32'h42);
      issue(1, 2'b00, 0, 3'b000, 32'h42, 0, 0, 23, 0);
`endif
      repeat (3) @(negedge clk);
      // Reset mid-BUSY drops the request
      mem(-1, 0);
      issue(1, 2'b01, 0, 3'b010, 32'h400, 0, 0, 15, 0);
      repeat (5) @(negedge clk);
      chk("busy_before_rst", {31'b0, dmem_req}, 32'h1);
      rst = 1;
      repeat (3) @(negedge clk);
      rst = 0;
      #2 chk_idle("midrst");
      @(negedge clk);
      #2 chk("midrst_req2", {31'b0, dmem_req}, 32'h0);
      @(negedge clk);
      exp_wb(24, 2'b00, 32'hA5);
      issue(1, 2'b00, 0, 3'b000, 32'hA5, 0, 0, 24, 0);
      repeat (5) @(negedge clk);
      #2;
      chk("left_hs", hs_q.size(), 0);
      chk("left_wb", wb_q.size(), 0);
      chk("left_stall", stall_q.size(), 0);
      chk("left_mem", mem_q.size(), 0);
      chk("left_err", err_n, 0);
      chk("left_mis", mis_n, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
